// File: rtl/aemb2_wbslv_ram.sv
// Wishbone classic-cycle slave in front of a single-port synchronous word RAM.
// Provides programmable wait states, byte-lane writes, an error response for
// addresses above the RAM, and abort when the strobe is withdrawn while waiting.
module aemb2_wbslv_ram #(
  parameter int unsigned AEMB_IWB = 32,
  parameter int unsigned MEM_AW   = 10,
  parameter int unsigned WAIT_CYC = 1
) (
  input  logic                gclk,
  input  logic                grst,
  input  logic                wb_cyc_i,
  input  logic                wb_stb_i,
  input  logic                wb_we_i,
  input  logic [AEMB_IWB-1:2] wb_adr_i,
  input  logic [3:0]          wb_sel_i,
  input  logic [31:0]         wb_dat_i,
  output logic [31:0]         wb_dat_o,
  output logic                wb_ack_o,
  output logic                wb_err_o,
  output logic                busy_o
);

  localparam int unsigned CNT_W = 4;
  localparam int unsigned DEPTH = 2 ** MEM_AW;
  localparam logic [CNT_W-1:0] CNT_LD = CNT_W'((WAIT_CYC > 0) ? WAIT_CYC - 1 : 0);

  typedef enum logic [1:0] {S_IDLE, S_WAIT, S_RESP} state_t;

  state_t             state_q, state_d;
  logic [CNT_W-1:0]   cnt_q, cnt_d;
  logic [MEM_AW-1:0]  idx_q, in_idx, rd_idx;
  logic               we_q, oor_q, in_oor;
  logic [3:0]         sel_q;
  logic [31:0]        dat_q;
  logic               req, ld, rd_en, wr_en, ack_d, err_d;
  logic [31:0]        mem [DEPTH];

  assign req    = wb_cyc_i & wb_stb_i;
  assign in_idx = wb_adr_i[MEM_AW+1:2];

  // Out-of-range flag: any address bit above the RAM window is set.
  if (MEM_AW + 2 < AEMB_IWB) begin : g_oor
    assign in_oor = |wb_adr_i[AEMB_IWB-1:MEM_AW+2];
  end else begin : g_no_oor
    assign in_oor = 1'b0;
  end

  // Next-state, counter and strobe decode.
  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    ld      = 1'b0;
    ack_d   = 1'b0;
    err_d   = 1'b0;
    rd_en   = 1'b0;
    wr_en   = 1'b0;
    rd_idx  = idx_q;
    case (state_q)
      S_IDLE: begin
        rd_idx = in_idx;
        if (req) begin
          ld = 1'b1;
          if (WAIT_CYC == 0) begin
            state_d = S_RESP;
            ack_d   = ~in_oor;
            err_d   = in_oor;
            rd_en   = ~wb_we_i & ~in_oor;
          end else begin
            state_d = S_WAIT;
            cnt_d   = CNT_LD;
          end
        end
      end
      S_WAIT: begin
        if (!req) begin
          state_d = S_IDLE;
        end else if (cnt_q == '0) begin
          state_d = S_RESP;
          ack_d   = ~oor_q;
          err_d   = oor_q;
          rd_en   = ~we_q & ~oor_q;
        end else begin
          cnt_d = cnt_q - CNT_W'(1);
        end
      end
      S_RESP: begin
        state_d = S_IDLE;
        wr_en   = we_q & ~oor_q;
      end
      default: state_d = S_IDLE;
    endcase
  end

  // State, wait counter and registered bus outputs.
  always_ff @(posedge gclk) begin
    if (grst) begin
      state_q  <= S_IDLE;
      cnt_q    <= '0;
      wb_ack_o <= 1'b0;
      wb_err_o <= 1'b0;
      busy_o   <= 1'b0;
      wb_dat_o <= 32'h0;
    end else begin
      state_q  <= state_d;
      cnt_q    <= cnt_d;
      wb_ack_o <= ack_d;
      wb_err_o <= err_d;
      busy_o   <= (state_d != S_IDLE);
      if (rd_en) wb_dat_o <= mem[rd_idx];
    end
  end

  // Holding registers capture the request at acceptance; later bus changes are ignored.
  always_ff @(posedge gclk) begin
    if (grst) begin
      idx_q <= '0;
      we_q  <= 1'b0;
      oor_q <= 1'b0;
      sel_q <= 4'h0;
      dat_q <= 32'h0;
    end else if (ld) begin
      idx_q <= in_idx;
      we_q  <= wb_we_i;
      oor_q <= in_oor;
      sel_q <= wb_sel_i;
      dat_q <= wb_dat_i;
    end
  end

  // Byte-lane RAM write at the edge ending the response cycle; reset discards it.
  always_ff @(posedge gclk) begin
    if (wr_en && !grst) begin
      for (int b = 0; b < 4; b++) begin
        if (sel_q[b]) mem[idx_q][8*b +: 8] <= dat_q[8*b +: 8];
      end
    end
  end

endmodule
